// File: rtl/rx_psdu_extractor_pkg.sv
// rtl/rx_psdu_extractor_pkg.sv - shared constants and state type for the PSDU extractor
package rx_pkg;

    localparam int SERVICE_BITS       = 16;
    localparam int SCRAMBLE_INIT_BITS = 7;
    localparam int DEF_LEN_W          = 12;

    typedef enum logic [1:0] {
        IDLE,
        SERVICE,
        DATA,
        DRAIN
    } rx_ext_state_t;

endpackage

// File: rtl/rx_psdu_extractor_if.sv
// rtl/rx_psdu_extractor_if.sv - bit-stream input and octet output bundle of the PSDU extractor
interface rx_psdu_extractor_if
    import rx_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W
);

    logic             start;
    logic [LEN_W-1:0] length;
    logic             bit_in;
    logic             bit_valid;
    logic [7:0]       byte_out;
    logic             byte_valid;
    logic             last;
    logic             done;
    logic             service_err;
    logic             busy;

    modport master (
        output start, length, bit_in, bit_valid,
        input  byte_out, byte_valid, last, done, service_err, busy
    );

    modport slave (
        input  start, length, bit_in, bit_valid,
        output byte_out, byte_valid, last, done, service_err, busy
    );

endinterface

// File: rtl/rx_psdu_extractor_bit_to_byte.sv
// rtl/rx_psdu_extractor_bit_to_byte.sv - LSB-first serial to octet packer with registered strobe
module bit_to_byte (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       bit_valid,
    input  logic       bit_in,
    output logic [7:0] byte_out,
    output logic       byte_rdy,
    output logic       octet_end
);

    logic [7:0] shift_q, shift_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] byte_out_q, byte_out_d;
    logic       byte_rdy_q, byte_rdy_d;

    // The bit arriving now completes an octet; lets the owner count octets in step with the strobe
    assign octet_end = bit_valid && !clr && (idx_q == 3'd7);

    // Shift new bits in from the top so the first bit ends up at bit 0 after eight shifts
    always_comb begin
        shift_d    = shift_q;
        idx_d      = idx_q;
        byte_out_d = byte_out_q;
        byte_rdy_d = 1'b0;
        if (clr) begin
            shift_d = 8'd0;
            idx_d   = 3'd0;
        end else if (bit_valid) begin
            shift_d = {bit_in, shift_q[7:1]};
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
                byte_out_d = {bit_in, shift_q[7:1]};
                byte_rdy_d = 1'b1;
            end
        end
    end

    // Packer state; the output octet is held until the next one completes
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q    <= 8'd0;
            idx_q      <= 3'd0;
            byte_out_q <= 8'd0;
            byte_rdy_q <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            byte_out_q <= byte_out_d;
            byte_rdy_q <= byte_rdy_d;
        end
    end

    assign byte_out = byte_out_q;
    assign byte_rdy = byte_rdy_q;

endmodule

// File: rtl/rx_psdu_extractor.sv
// rtl/rx_psdu_extractor.sv - strips SERVICE, packs LENGTH PSDU octets and drops tail/pad bits
module rx_psdu_extractor
    import rx_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W
) (
    input logic                clk,
    input logic                rst,
    rx_psdu_extractor_if.slave bus
);

    localparam logic [3:0] SVC_LAST  = 4'(SERVICE_BITS - 1);
    localparam logic [3:0] INIT_BITS = 4'(SCRAMBLE_INIT_BITS);

    rx_ext_state_t    state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] oct_cnt_q, oct_cnt_d;
    logic [LEN_W-1:0] oct_cnt_inc;
    logic [3:0]       svc_cnt_q, svc_cnt_d;
    logic             service_err_q, service_err_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             data_bit_valid;
    logic             octet_end;
    logic             byte_rdy;
    logic [7:0]       byte_val;

    // A start always wins over a coincident bit, so the packer never sees that bit
    assign data_bit_valid = bus.bit_valid && !bus.start && (state_q == DATA);
    assign oct_cnt_inc    = oct_cnt_q + 1'b1;

    bit_to_byte u_bit_to_byte (
        .clk       (clk),
        .rst       (rst),
        .clr       (bus.start),
        .bit_valid (data_bit_valid),
        .bit_in    (bus.bit_in),
        .byte_out  (byte_val),
        .byte_rdy  (byte_rdy),
        .octet_end (octet_end)
    );

    // Packet sequencing: SERVICE skip and check, octet counting, end-of-packet strobes
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        oct_cnt_d     = oct_cnt_q;
        svc_cnt_d     = svc_cnt_q;
        service_err_d = service_err_q;
        last_d        = 1'b0;
        done_d        = 1'b0;
        busy_d        = done_q ? 1'b0 : busy_q;

        if (bus.start) begin
            state_d       = SERVICE;
            len_d         = bus.length;
            oct_cnt_d     = '0;
            svc_cnt_d     = 4'd0;
            service_err_d = 1'b0;
            busy_d        = 1'b1;
        end else begin
            case (state_q)
                SERVICE: begin
                    if (bus.bit_valid) begin
                        svc_cnt_d = svc_cnt_q + 4'd1;
                        if ((svc_cnt_q < INIT_BITS) && bus.bit_in) begin
                            service_err_d = 1'b1;
                        end
                        if (svc_cnt_q == SVC_LAST) begin
                            if (len_q != '0) begin
                                state_d = DATA;
                            end else begin
                                done_d  = 1'b1;
                                state_d = DRAIN;
                            end
                        end
                    end
                end
                DATA: begin
                    if (octet_end) begin
                        oct_cnt_d = oct_cnt_inc;
                        if (oct_cnt_inc == len_q) begin
                            last_d  = 1'b1;
                            done_d  = 1'b1;
                            state_d = DRAIN;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            len_q         <= '0;
            oct_cnt_q     <= '0;
            svc_cnt_q     <= 4'd0;
            service_err_q <= 1'b0;
            last_q        <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            oct_cnt_q     <= oct_cnt_d;
            svc_cnt_q     <= svc_cnt_d;
            service_err_q <= service_err_d;
            last_q        <= last_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.byte_out    = byte_val;
    assign bus.byte_valid  = byte_rdy;
    assign bus.last        = last_q;
    assign bus.done        = done_q;
    assign bus.service_err = service_err_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_rx_psdu_extractor.sv
// tb/tb_rx_psdu_extractor.sv - self-checking bench for the PSDU extractor
module tb_rx_psdu_extractor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rx_psdu_extractor_if #(.LEN_W(12)) bus ();

    rx_psdu_extractor #(.LEN_W(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] b;
        logic       l;
        int         e;
    } obs_t;

    typedef struct {
        logic [11:0] len;
        logic [15:0] svc;
        logic [7:0]  d0_tx;
        logic [7:0]  d1_tx;
        int          gap;
        logic [7:0]  e0;
        logic [7:0]  e1;
        logic        err;
    } vec_t;

    int         n_pass  = 0;
    int         n_total = 0;
    int         edge_n  = 0;
    obs_t       obs_q[$];
    int         done_e[$];
    logic       done_busy[$];
    logic       tx_bits[$];
    logic [7:0] exp_bytes[$];
    vec_t       vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (bus.byte_valid === 1'b1) obs_q.push_back('{b: bus.byte_out, l: bus.last, e: edge_n});
        if (bus.done === 1'b1) begin
            done_e.push_back(edge_n);
            done_busy.push_back(bus.busy);
        end
    end

    task automatic step(input logic s, input logic [11:0] l, input logic b, input logic v);
        bus.start     = s;
        bus.length    = l;
        bus.bit_in    = b;
        bus.bit_valid = v;
        @(posedge clk);
        #1;
        edge_n++;
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gap);
        if (gap == 1) repeat ($urandom_range(0, 2)) step(1'b0, 12'd0, 1'($urandom), 1'b0);
        else if (gap == 2) step(1'b0, 12'd0, 1'($urandom), 1'b0);
        step(1'b0, 12'd0, b, 1'b1);
    endtask

    task automatic gen_random(input int len);
        logic [7:0] b;
        tx_bits.delete();
        exp_bytes.delete();
        for (int o = 0; o < len; o++) begin
            b = 8'($urandom);
            exp_bytes.push_back(b);
            for (int k = 0; k < 8; k++) tx_bits.push_back(b[k]);
        end
    endtask

    task automatic run_packet(input logic [11:0] len, input logic [15:0] svc, input int gap,
                              input int pad, input logic exp_err);
        int exp_edge[$];
        int exp_done;
        int n;
        exp_done = -1;
        obs_q.delete();
        done_e.delete();
        done_busy.delete();
        step(1'b1, len, 1'($urandom), 1'($urandom_range(0, 1)));
        chk("busy_rise", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 16; i++) begin
            send_bit(svc[i], gap);
            if (i == 15 && len == 12'd0) exp_done = edge_n;
        end
        n = tx_bits.size();
        for (int i = 0; i < n; i++) begin
            send_bit(tx_bits[i], gap);
            if (i % 8 == 7) exp_edge.push_back(edge_n);
            if (i == n - 1) exp_done = edge_n;
        end
        for (int i = 0; i < pad; i++) send_bit(1'($urandom), gap);
        step(1'b0, 12'd0, 1'b0, 1'b0);
        step(1'b0, 12'd0, 1'b0, 1'b0);
        chk("byte_count", 32'(obs_q.size()), 32'(exp_bytes.size()));
        for (int i = 0; i < exp_bytes.size(); i++) begin
            if (i < obs_q.size()) begin
                chk("byte_value", 32'(obs_q[i].b), 32'(exp_bytes[i]));
                chk("byte_last", 32'(obs_q[i].l), 32'(i == exp_bytes.size() - 1));
                chk("byte_latency", 32'(obs_q[i].e), 32'(exp_edge[i]));
            end
        end
        chk("done_count", 32'(done_e.size()), 32'd1);
        if (done_e.size() >= 1) begin
            chk("done_time", 32'(done_e[0]), 32'(exp_done));
            chk("busy_at_done", 32'(done_busy[0]), 32'd1);
        end
        chk("service_err", 32'(bus.service_err), 32'(exp_err));
        chk("busy_fall", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [11:0] rlen;
        logic [15:0] rsvc;

        vecs[0] = '{12'd2, 16'h0000, 8'b10110000, 8'b01111111, 0, 8'h0D, 8'hFE, 1'b0};
        vecs[1] = '{12'd1, 16'h0008, 8'b10100101, 8'b00000000, 2, 8'hA5, 8'h00, 1'b1};
        vecs[2] = '{12'd0, 16'hFF80, 8'b00000000, 8'b00000000, 0, 8'h00, 8'h00, 1'b0};
        vecs[3] = '{12'd1, 16'h0040, 8'b11110000, 8'b00000000, 1, 8'h0F, 8'h00, 1'b1};
        vecs[4] = '{12'd2, 16'h0001, 8'b00000001, 8'b11000000, 0, 8'h80, 8'h03, 1'b1};

        bus.start = 1'b0; bus.length = 12'd0; bus.bit_in = 1'b0; bus.bit_valid = 1'b0;
        rst = 1'b1;
        repeat (3) step(1'b0, 12'd0, 1'b1, 1'b1);
        chk("rst_byte_out", 32'(bus.byte_out), 32'd0);
        chk("rst_byte_valid", 32'(bus.byte_valid), 32'd0);
        chk("rst_last", 32'(bus.last), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_service_err", 32'(bus.service_err), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        step(1'b0, 12'd0, 1'b0, 1'b0);

        for (int v = 0; v < 5; v++) begin
            tx_bits.delete();
            exp_bytes.delete();
            if (vecs[v].len >= 12'd1) begin
                for (int k = 7; k >= 0; k--) tx_bits.push_back(vecs[v].d0_tx[k]);
                exp_bytes.push_back(vecs[v].e0);
            end
            if (vecs[v].len >= 12'd2) begin
                for (int k = 7; k >= 0; k--) tx_bits.push_back(vecs[v].d1_tx[k]);
                exp_bytes.push_back(vecs[v].e1);
            end
            run_packet(vecs[v].len, vecs[v].svc, vecs[v].gap, 22, vecs[v].err);
        end

        step(1'b1, 12'd1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 0);
        chk("svc_err_before_bit3", 32'(bus.service_err), 32'd0);
        send_bit(1'b1, 0);
        chk("svc_err_after_bit3", 32'(bus.service_err), 32'd1);
        for (int i = 0; i < 20; i++) send_bit(1'b0, 0);
        step(1'b0, 12'd0, 1'b0, 1'b0);
        chk("svc_err_held_after_done", 32'(bus.service_err), 32'd1);
        step(1'b1, 12'd1, 1'b0, 1'b0);
        chk("svc_err_cleared_by_start", 32'(bus.service_err), 32'd0);

        obs_q.delete();
        done_e.delete();
        step(1'b1, 12'd10, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) send_bit(1'b0, 0);
        for (int i = 0; i < 21; i++) send_bit(1'($urandom), 0);
        chk("abort_prefix_bytes", 32'(obs_q.size()), 32'd2);
        chk("abort_prefix_done", 32'(done_e.size()), 32'd0);
        gen_random(1);
        run_packet(12'd1, 16'h0000, 0, 5, 1'b0);

        step(1'b1, 12'd3, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) send_bit(1'b0, 0);
        for (int i = 0; i < 12; i++) send_bit(1'b1, 0);
        chk("rst_mid_pre_byte", 32'(bus.byte_out), 32'hFF);
        chk("rst_mid_pre_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        step(1'b0, 12'd0, 1'b1, 1'b1);
        rst = 1'b0;
        chk("rst_mid_byte_out", 32'(bus.byte_out), 32'd0);
        chk("rst_mid_byte_valid", 32'(bus.byte_valid), 32'd0);
        chk("rst_mid_last", 32'(bus.last), 32'd0);
        chk("rst_mid_done", 32'(bus.done), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        obs_q.delete();
        done_e.delete();
        for (int i = 0; i < 24; i++) step(1'b0, 12'd0, 1'($urandom), 1'b1);
        chk("idle_ignores_bytes", 32'(obs_q.size()), 32'd0);
        chk("idle_ignores_done", 32'(done_e.size()), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        for (int r = 0; r < 20; r++) begin
            rlen = 12'($urandom_range(0, 6));
            rsvc = 16'($urandom);
            if ($urandom_range(0, 1) == 1) rsvc[6:0] = 7'd0;
            gen_random(int'(rlen));
            run_packet(rlen, rsvc, $urandom_range(0, 2), $urandom_range(0, 30), |rsvc[6:0]);
        end

        gen_random(4095);
        run_packet(12'hFFF, 16'h0000, 0, 4, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rx_psdu_extractor.md
# rx_psdu_extractor

Receive-chain back end placed directly after the descrambler. It consumes the descrambled serial bit stream (one bit per valid cycle) and strips the 16-bit SERVICE field. It then packs PSDU bits LSB-first into octets, stops after LENGTH octets, and discards the tail and pad bits that remain in the DATA field. It also flags a non-zero scrambler-init section of SERVICE.

## Interface
Parameters:
- LEN_W, 12: width of PSDU length in octets (802.11a LENGTH field).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; latches `length` and arms a new packet.
- length  in  LEN_W  PSDU octet count; sampled only when `start`=1.
- bit_in  in  1  descrambled data bit.
- bit_valid  in  1  `bit_in` is valid this cycle; no backpressure exists.
- byte_out  out  8  assembled PSDU octet; first received bit sits at bit 0.
- byte_valid  out  1  one-cycle strobe; `byte_out` is valid.
- last  out  1  asserted with `byte_valid` on the final octet.
- done  out  1  one-cycle pulse at packet completion.
- service_err  out  1  sticky per packet; set if any of SERVICE bits 0..6 is 1.
- busy  out  1  high from `start` until completion.

## Operation
- States: IDLE, SERVICE, DATA, DRAIN.
- IDLE:
  - `bit_valid` bits are ignored.
  - On `start`: latch `length`, clear `service_err`, clear the bit and byte counters, go to SERVICE.
- SERVICE:
  - Counts 16 valid bits with a 4-bit counter. Bits are not output.
  - Bits 0..6 are checked for zero; any 1 sets `service_err`.
  - After the 16th bit: go to DATA if the latched length is non-zero.
  - If the latched length is 0: pulse `done` and go to DRAIN.
- DATA:
  - Valid bits shift into an 8-bit register LSB-first, tracked by a 3-bit index.
  - On the 8th bit: register the octet out, increment the octet counter, and wrap the index to 0.
  - When the octet counter reaches the latched length: assert `last` and `done` with that `byte_valid`, then go to DRAIN.
- DRAIN:
  - Discards all bits (tail + pad) until the next `start`. `busy`=0.
  - A `start` in DRAIN behaves exactly as in IDLE.
- A `start` in SERVICE or DATA aborts the current packet:
  - No `done` is issued for the aborted packet.
  - No partial octet is emitted.
  - The new packet begins exactly as from IDLE.
- A `start` and a `bit_valid` in the same cycle: the bit is ignored; counting starts with the next valid bit.
- `rst` at any time forces IDLE and clears all counters and outputs, including mid-packet.
- The octet counter is LEN_W bits wide. The compare is an equality against the latched length, so a length of 2^LEN_W−1 completes without wrap.

## Timing
- Reset values: `byte_out`=0, `byte_valid`=0, `last`=0, `done`=0, `service_err`=0, `busy`=0.
- `busy` rises the cycle after `start` and falls the cycle after `done`.
- Latency: `byte_valid` is asserted 1 cycle after the cycle carrying the octet's 8th valid bit.
- `byte_out` holds its value until the next octet.
- `byte_valid`, `last` and `done` are single-cycle strobes.
- Gaps in `bit_valid` stall all counting; there is no timeout.
- `service_err` updates 1 cycle after the offending bit and holds until the next `start` or `rst`.
- Minimum `byte_valid` spacing is 8 cycles at full input rate.

## Structure
- Shared package `rx_pkg`:
  - SERVICE_BITS=16 and SCRAMBLE_INIT_BITS=7.
  - The LEN_W default.
  - A state enum `rx_ext_state_t` {IDLE, SERVICE, DATA, DRAIN}.
- One natural sub-module: `bit_to_byte`.
  - Contains the 8-bit LSB-first shift register, the 3-bit index and the registered output strobe.
  - Inputs: `clr` and `bit_valid`. Output: octet with `byte_rdy`.
- The top level holds the FSM, the SERVICE check and the octet counter.

## Test plan
- `length`=2, SERVICE=16 zeros, then data bits 1,0,1,1,0,0,0,0 and 0,1,1,1,1,1,1,1, then 22 tail/pad bits, all at full rate -> `byte_out`=0x0D then 0xFE. `last` and `done` come with the second octet; pad bits produce no output; `busy` falls one cycle after `done`.
- SERVICE bit 3 = 1, `length`=1 -> `service_err`=1 from the cycle after bit 3, held through `done`. A new `start` clears it.
- `length`=0 -> no `byte_valid`; `done` pulses 1 cycle after the 16th SERVICE bit.
- `bit_valid` toggling every other cycle with `length`=1 (octet 0xA5) -> a single `byte_valid` 1 cycle after the 8th valid data bit, carrying 0xA5.
- `start` while 5 bits into octet 3 of a `length`=10 packet -> no partial octet and no `done`. The new packet's first octet is correct after its own 16 SERVICE bits.
- `rst` asserted mid-DATA for 1 cycle -> all outputs 0 the next cycle; FSM in IDLE; bits ignored until `start`.
